// File: rtl/beat_pkg.sv
// Shared definitions for the beat link (generator and decoder sides).
//   - Default tempo parameters (BASE_CYC, TOL, LOCK_CNT, CNT_W).
//   - nominal_period(): clocks between beats for a tempo code.
//   - Decoder FSM state encoding and the classifier result struct.
package beat_pkg;

    localparam int BASE_CYC_DEF = 16;
    localparam int TOL_DEF      = 2;
    localparam int LOCK_CNT_DEF = 3;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } beat_state_e;

    typedef struct packed {
        logic       match;
        logic [2:0] code;
    } beat_class_t;

    // Code 7 is the fastest tempo; code 0 the slowest.
    function automatic int nominal_period(input int base_cyc, input int code);
        return base_cyc * (8 - code);
    endfunction

endpackage

// File: rtl/beat_decoder_if.sv
// Signal bundle between a beat source/observer and the beat decoder.
//   pulse       : beat train into the decoder (asynchronous to clk)
//   S           : recovered tempo code
//   locked      : decoder is in LOCKED
//   led         : registered copy of locked
//   code_strobe : one-cycle pulse when S is (re)loaded
//   err         : one-cycle pulse on bad interval or timeout
//   dbg_state   : decoder FSM state, for observation only
// master = the side driving pulse; slave = the decoder.
interface beat_decoder_if;
    import beat_pkg::*;

    logic        pulse;
    logic [2:0]  S;
    logic        locked;
    logic        led;
    logic        code_strobe;
    logic        err;
    beat_state_e dbg_state;

    modport master (
        output pulse,
        input  S, locked, led, code_strobe, err, dbg_state
    );

    modport slave (
        input  pulse,
        output S, locked, led, code_strobe, err, dbg_state
    );

endinterface

// File: rtl/beat_classify.sv
// Combinational interval classifier.
//   iv_i  : measured rising-to-rising interval in clocks
//   cls_o : match=1 and code=k when |iv_i - N_k| <= TOL for some k
// With 2*TOL < BASE_CYC the tolerance windows never overlap, so at most
// one comparator can hit and the encoder below needs no real priority.
module beat_classify
    import beat_pkg::*;
#(
    parameter int BASE_CYC = BASE_CYC_DEF,
    parameter int TOL      = TOL_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] iv_i,
    output beat_class_t      cls_o
);

    localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);

    logic [7:0] hit;

    for (genvar k = 0; k < 8; k++) begin : g_cmp
        localparam int                    NK   = nominal_period(BASE_CYC, k);
        localparam logic signed [CNT_W:0] NK_S = (CNT_W+1)'(NK);

        // One extra bit so iv - N_k can go negative without wrapping.
        logic signed [CNT_W:0] diff;

        assign diff   = $signed({1'b0, iv_i}) - NK_S;
        assign hit[k] = (diff <= TOL_S) && (diff >= -TOL_S);
    end

    always_comb begin
        cls_o = '0;
        for (int k = 0; k < 8; k++) begin
            if (hit[k]) begin
                cls_o.match = 1'b1;
                cls_o.code  = 3'(k);
            end
        end
    end

endmodule

// File: rtl/beat_decoder.sv
// Beat link receiver: measures the spacing of rising edges on pulse and
// recovers the tempo code the generator used.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low; clears all state
//   bus   : beat_decoder_if.slave (pulse in; S, locked, led, code_strobe,
//           err, dbg_state out)
// An edge is seen two clocks after pulse is first sampled high; locked,
// code_strobe and err are registered one clock after that edge; led lags
// locked by one more clock.
module beat_decoder
    import beat_pkg::*;
#(
    parameter int BASE_CYC = BASE_CYC_DEF,
    parameter int TOL      = TOL_DEF,      // must satisfy 2*TOL < BASE_CYC
    parameter int LOCK_CNT = LOCK_CNT_DEF,
    parameter int CNT_W    = CNT_W_DEF     // must hold 8*BASE_CYC+TOL+1
) (
    input  logic          clk,
    input  logic          reset,
    beat_decoder_if.slave bus
);

    localparam int MCNT_W = $clog2(LOCK_CNT + 1);

    // Longest legal interval is N_0+TOL; one clock past that is a dead link.
    localparam logic [CNT_W-1:0] TIMEOUT_IV =
        CNT_W'(nominal_period(BASE_CYC, 0) + TOL + 1);

    // Input synchroniser and edge detector
    logic [1:0] sync_q;
    logic       dly_q;
    logic       beat_edge;

    // Interval counter
    logic [CNT_W-1:0] iv_q, iv_d;
    beat_class_t      cls;
    logic             timeout;

    // FSM and output registers
    beat_state_e      state_q, state_d;
    logic [2:0]       cand_q, cand_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic [2:0]       s_q, s_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic             led_q;
    logic             locked_w;

    assign beat_edge = sync_q[1] & ~dly_q;

    // Interval as seen on an edge equals the rising-to-rising spacing:
    // the edge cycle reloads 1, every other cycle counts up, stopping at
    // all-ones so an idle link never wraps back into a legal window.
    always_comb begin
        if (beat_edge) begin
            iv_d = CNT_W'(1);
        end else if (&iv_q) begin
            iv_d = iv_q;
        end else begin
            iv_d = iv_q + CNT_W'(1);
        end
    end

    beat_classify #(
        .BASE_CYC (BASE_CYC),
        .TOL      (TOL),
        .CNT_W    (CNT_W)
    ) u_classify (
        .iv_i  (iv_q),
        .cls_o (cls)
    );

    // An edge arriving in the timeout cycle is measured instead.
    assign timeout = (state_q != IDLE) && (iv_q == TIMEOUT_IV) && !beat_edge;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= 2'b00;
            dly_q    <= 1'b0;
            iv_q     <= '0;
            state_q  <= IDLE;
            cand_q   <= 3'd0;
            mcnt_q   <= '0;
            s_q      <= 3'd0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], bus.pulse};
            dly_q    <= sync_q[1];
            iv_q     <= iv_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            mcnt_q   <= mcnt_d;
            s_q      <= s_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
            led_q    <= locked_w;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        mcnt_d   = mcnt_q;
        s_d      = s_q;
        strobe_d = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The spacing before the first edge is unknown, so this
                // edge only opens the first measurement.
                if (beat_edge) begin
                    state_d = ACQ;
                    cand_d  = 3'd0;
                    mcnt_d  = '0;
                end
            end

            ACQ: begin
                if (beat_edge) begin
                    if (cls.match && cls.code == cand_q) begin
                        mcnt_d = mcnt_q + MCNT_W'(1);
                        if (mcnt_q == MCNT_W'(LOCK_CNT - 1)) begin
                            state_d  = LOCKED;
                            s_d      = cand_q;
                            strobe_d = 1'b1;
                        end
                    end else if (cls.match) begin
                        cand_d = cls.code;
                        mcnt_d = MCNT_W'(1);
                    end else begin
                        mcnt_d = '0;
                        err_d  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end

            LOCKED: begin
                if (beat_edge) begin
                    if (cls.match && cls.code != s_q) begin
                        // A clean interval of another tempo already counts
                        // as the first vote for the new code.
                        state_d = ACQ;
                        cand_d  = cls.code;
                        mcnt_d  = MCNT_W'(1);
                    end else if (!cls.match) begin
                        state_d = ACQ;
                        mcnt_d  = '0;
                        err_d   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        locked_w        = (state_q == LOCKED);
        bus.S           = s_q;
        bus.locked      = locked_w;
        bus.led         = led_q;
        bus.code_strobe = strobe_q;
        bus.err         = err_q;
        bus.dbg_state   = state_q;
    end

endmodule

// File: tb/tb_beat_decoder.sv
// Self-checking bench for beat_decoder.
module tb_beat_decoder;
  import beat_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  beat_decoder_if bus ();

  beat_decoder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- scoreboard ----------------
  // Expected vector: {state[1:0], S[2:0], locked, led, code_strobe, err}
  localparam int W = 9;
  logic [W-1:0] exp_q[$];

  int  strobe_seen = 0;
  int  err_seen = 0;
  logic locked_prev = 1'b0;
  time lock_rise_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on whole intervals: the number of clocks between two processed
  // edges, classified against BASE*(8-k) +/- TOL by plain arithmetic.
  typedef enum int {M_WAIT, M_HUNT, M_HOLD} mphase_t;

  function automatic int tempo_of(input int ivl);
    int k;
    k = -1;
    for (int c = 0; c < 8; c++) begin
      if (ivl >= 16 * (8 - c) - 2 && ivl <= 16 * (8 - c) + 2) k = c;
    end
    return k;
  endfunction

  function automatic logic [1:0] phase_code(input mphase_t p);
    case (p)
      M_HUNT:  return 2'(ACQ);
      M_HOLD:  return 2'(LOCKED);
      default: return 2'(IDLE);
    endcase
  endfunction

  initial begin : model
    mphase_t m_phase;
    int m_cand, m_mcnt, m_s, m_cyc, m_last, ivl, k;
    logic m_locked, m_led, m_strobe, m_err, p_prev, r1, r2, ev;
    m_phase = M_WAIT; m_cand = 0; m_mcnt = 0; m_s = 0; m_cyc = 0; m_last = 0;
    m_locked = 0; p_prev = 0; r1 = 0; r2 = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = M_WAIT; m_cand = 0; m_mcnt = 0; m_s = 0; m_cyc = 0; m_last = 0;
        m_locked = 0; p_prev = 0; r1 = 0; r2 = 0;
        exp_q.delete();
      end else begin
        m_cyc++;
        m_led = m_locked;
        m_strobe = 0;
        m_err = 0;
        // A rise sampled on this edge is acted on two edges later.
        ev = r2;
        r2 = r1;
        r1 = bus.pulse && !p_prev;
        p_prev = bus.pulse;
        if (ev) begin
          ivl = m_cyc - m_last;
          m_last = m_cyc;
          k = tempo_of(ivl);
          case (m_phase)
            M_WAIT: begin
              m_phase = M_HUNT; m_cand = 0; m_mcnt = 0;
            end
            M_HUNT: begin
              if (k >= 0 && k == m_cand) begin
                m_mcnt++;
                if (m_mcnt == 3) begin
                  m_phase = M_HOLD; m_s = m_cand; m_strobe = 1;
                end
              end else if (k >= 0) begin
                m_cand = k; m_mcnt = 1;
              end else begin
                m_mcnt = 0; m_err = 1;
              end
            end
            default: begin
              if (k >= 0 && k != m_s) begin
                m_phase = M_HUNT; m_cand = k; m_mcnt = 1;
              end else if (k < 0) begin
                m_phase = M_HUNT; m_mcnt = 0; m_err = 1;
              end
            end
          endcase
        end else if (m_phase != M_WAIT && (m_cyc - m_last) == 131) begin
          m_phase = M_WAIT; m_err = 1;
        end
        m_locked = (m_phase == M_HOLD);
        exp_q.push_back({phase_code(m_phase), 3'(m_s), m_locked, m_led, m_strobe, m_err});
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin : compare
    logic [W-1:0] v;
    forever begin
      @(negedge clk);
      if (bus.code_strobe === 1'b1) strobe_seen++;
      if (bus.err === 1'b1) err_seen++;
      if (bus.locked === 1'b1 && !locked_prev) lock_rise_t = $time;
      locked_prev = bus.locked;
      if (!reset) begin
        v = '0;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_underflow: got empty queue, expected an entry at %0t", $time);
        continue;
      end else begin
        v = exp_q.pop_front();
      end
      chk("state",       32'(bus.dbg_state),   32'(v[8:7]));
      chk("S",           32'(bus.S),           32'(v[6:4]));
      chk("locked",      32'(bus.locked),      32'(v[3]));
      chk("led",         32'(bus.led),         32'(v[2]));
      chk("code_strobe", 32'(bus.code_strobe), 32'(v[1]));
      chk("err",         32'(bus.err),         32'(v[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a falling edge; the next rise follows `per` clocks later.
  task automatic send_pulse(input int per);
    bus.pulse = 1'b1;
    repeat (3) @(negedge clk);
    bus.pulse = 1'b0;
    repeat (per - 3) @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    n_errors++;
    $display("FAIL watchdog: got no end of test, expected finish before %0t", $time);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin : main
    int s0, e0;
    time t_start;
    bus.pulse = 1'b0;

    #20;
    chk("rst_S", 32'(bus.S), 0);
    chk("rst_locked", 32'(bus.locked), 0);
    #3 reset = 1'b1;
    @(negedge clk);

    // 1: 16-clk spacing locks to code 7
    s0 = strobe_seen; e0 = err_seen;
    repeat (3) send_pulse(16);
    t_start = $time;
    send_pulse(16);
    repeat (2) send_pulse(16);
    chk("t1_lock_latency", 32'((lock_rise_t - t_start) / 10), 3);
    chk("t1_S", 32'(bus.S), 7);
    chk("t1_locked", 32'(bus.locked), 1);
    chk("t1_led", 32'(bus.led), 1);
    chk("t1_strobes", 32'(strobe_seen - s0), 1);
    chk("t1_errs", 32'(err_seen - e0), 0);

    // 2: switch to 128-clk spacing, relock on code 0
    s0 = strobe_seen; e0 = err_seen;
    repeat (2) send_pulse(128);
    chk("t2_drop", 32'(bus.locked), 0);
    send_pulse(128);
    chk("t2_not_yet", 32'(bus.locked), 0);
    send_pulse(128);
    chk("t2_relock", 32'(bus.locked), 1);
    chk("t2_S", 32'(bus.S), 0);
    chk("t2_strobes", 32'(strobe_seen - s0), 1);
    chk("t2_errs", 32'(err_seen - e0), 0);

    // 3: 62/66 jitter around N_4, then a 67-clk interval
    s0 = strobe_seen; e0 = err_seen;
    send_pulse(62); send_pulse(66); send_pulse(62); send_pulse(66); send_pulse(62);
    chk("t3_lock", 32'(bus.locked), 1);
    chk("t3_S", 32'(bus.S), 4);
    send_pulse(67);
    send_pulse(64);
    chk("t3_bad_drop", 32'(bus.locked), 0);
    chk("t3_bad_err", 32'(err_seen - e0), 1);
    repeat (3) send_pulse(64);
    chk("t3_relock", 32'(bus.locked), 1);
    chk("t3_S2", 32'(bus.S), 4);
    chk("t3_strobes", 32'(strobe_seen - s0), 2);

    // 4: pulse stops -> timeout
    e0 = err_seen;
    repeat (80) @(negedge clk);
    chk("t4_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("t4_locked", 32'(bus.locked), 0);
    chk("t4_S_hold", 32'(bus.S), 4);
    chk("t4_err", 32'(err_seen - e0), 1);

    // 5: reset during acquisition
    send_pulse(32);
    send_pulse(32);
    e0 = err_seen;
    #2 reset = 1'b0;
    #1;
    chk("t5_S", 32'(bus.S), 0);
    chk("t5_locked", 32'(bus.locked), 0);
    chk("t5_led", 32'(bus.led), 0);
    chk("t5_strobe", 32'(bus.code_strobe), 0);
    chk("t5_err", 32'(bus.err), 0);
    chk("t5_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    s0 = strobe_seen;
    repeat (3) send_pulse(32);
    chk("t5_first_edge_free", 32'(bus.locked), 0);
    send_pulse(32);
    chk("t5_lock", 32'(bus.locked), 1);
    chk("t5_S6", 32'(bus.S), 6);
    chk("t5_strobes", 32'(strobe_seen - s0), 1);
    chk("t5_errs", 32'(err_seen - e0), 0);

    // 6: tempo sweep 7..0, ~2000 clks per setting
    pulse_reset();
    e0 = err_seen;
    for (int k = 7; k >= 0; k--) begin
      int per;
      per = 16 * (8 - k);
      s0 = strobe_seen;
      repeat (2000 / per) send_pulse(per);
      chk("t6_S", 32'(bus.S), 32'(k));
      chk("t6_strobes", 32'(strobe_seen - s0), 1);
    end
    chk("t6_errs", 32'(err_seen - e0), 0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
